// File: rtl/cat_trap_pkg.sv
// Shared types for the cat-trap game: cell, result, direction and sequencer state encodings.
package cat_trap_pkg;

  localparam int unsigned BOARD_ROWS = 6;
  localparam int unsigned BOARD_COLS = 7;
  localparam int unsigned BOARD_RW   = 3;
  localparam int unsigned BOARD_CW   = 3;
  localparam int unsigned CAT_START_R = 3;
  localparam int unsigned CAT_START_C = 3;

  typedef enum logic [1:0] {
    CELL_EMPTY = 2'd0,
    CELL_BLOCK = 2'd1,
    CELL_CAT   = 2'd2
  } cell_t;

  typedef enum logic [1:0] {
    RES_MOVED   = 2'd0,
    RES_TRAPPED = 2'd1,
    RES_ESCAPED = 2'd2,
    RES_ILLEGAL = 2'd3
  } result_t;

  typedef enum logic [1:0] {
    DIR_DOWN  = 2'd0,
    DIR_UP    = 2'd1,
    DIR_RIGHT = 2'd2,
    DIR_LEFT  = 2'd3
  } dir_t;

  typedef enum logic [3:0] {
    ST_INIT,
    ST_IDLE,
    ST_WR_BLOCK,
    ST_EVAL,
    ST_CHK,
    ST_WR_CAT,
    ST_CLR_OLD,
    ST_DONE,
    ST_OVER
  } state_t;

endpackage

// File: rtl/cat_nbr_calc.sv
// Neighbour of the cat cell in a given direction, with a flag when that neighbour leaves the board.
module cat_nbr_calc
  import cat_trap_pkg::*;
#(
  parameter int unsigned ROWS = BOARD_ROWS,
  parameter int unsigned COLS = BOARD_COLS,
  parameter int unsigned RW   = BOARD_RW,
  parameter int unsigned CW   = BOARD_CW
) (
  input  logic [RW-1:0] cat_row,
  input  logic [CW-1:0] cat_col,
  input  dir_t          dir,
  output logic [RW-1:0] nbr_row,
  output logic [CW-1:0] nbr_col,
  output logic          off_grid
);

  always_comb begin
    nbr_row  = cat_row;
    nbr_col  = cat_col;
    off_grid = 1'b0;
    case (dir)
      DIR_DOWN: begin
        nbr_row  = cat_row + RW'(1);
        off_grid = (cat_row == RW'(ROWS - 1));
      end
      DIR_UP: begin
        nbr_row  = cat_row - RW'(1);
        off_grid = (cat_row == RW'(0));
      end
      DIR_RIGHT: begin
        nbr_col  = cat_col + CW'(1);
        off_grid = (cat_col == CW'(COLS - 1));
      end
      default: begin
        nbr_col  = cat_col - CW'(1);
        off_grid = (cat_col == CW'(0));
      end
    endcase
  end

endmodule

// File: rtl/cat_move_sequencer.sv
// Sequences board-memory accesses for one cat-trap turn: init sweep, block write, neighbour probes, cat move.
// Build option CAT_ROUND_ROBIN_EN rotates the first probed direction after every successful move.
module cat_move_sequencer
  import cat_trap_pkg::*;
#(
  parameter int unsigned ROWS   = BOARD_ROWS,
  parameter int unsigned COLS   = BOARD_COLS,
  parameter int unsigned RW     = BOARD_RW,
  parameter int unsigned CW     = BOARD_CW,
  parameter int unsigned CAT_R0 = CAT_START_R,
  parameter int unsigned CAT_C0 = CAT_START_C
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          place_valid,
  input  logic [RW-1:0] place_row,
  input  logic [CW-1:0] place_col,
  output logic          place_ready,
  input  logic          restart,
  output logic          mem_en,
  output logic          mem_we,
  output logic [RW-1:0] mem_row,
  output logic [CW-1:0] mem_col,
  output logic [1:0]    mem_wdata,
  input  logic [1:0]    mem_rdata,
  output logic [RW-1:0] cat_row,
  output logic [CW-1:0] cat_col,
  output logic          busy,
  output logic          done,
  output logic [1:0]    result
);

  state_t        state, state_n;
  logic [RW-1:0] init_row, init_row_n;
  logic [CW-1:0] init_col, init_col_n;
  logic          init_fin, init_fin_n;
  dir_t          dir, dir_n, dir_sel, start_dir;
  logic [1:0]    probe, probe_n;
  logic [RW-1:0] nbr_row_q, nbr_row_n, nbr_row;
  logic [CW-1:0] nbr_col_q, nbr_col_n, nbr_col;
  logic          off_grid;
  logic [RW-1:0] cat_row_n, mem_row_n;
  logic [CW-1:0] cat_col_n, mem_col_n;
  logic [1:0]    result_n, mem_wdata_n;
  logic          done_n, place_ready_n, mem_en_n, mem_we_n, illegal;

  // In CHK the neighbour for the next probe is needed to schedule its read.
  assign dir_sel = (state == ST_CHK) ? dir_t'(dir + 2'd1) : dir;
  assign busy    = (state != ST_IDLE) && (state != ST_OVER);
  assign illegal = (32'(place_row) >= ROWS) || (32'(place_col) >= COLS) ||
                   ((place_row == cat_row) && (place_col == cat_col));

  cat_nbr_calc #(.ROWS(ROWS), .COLS(COLS), .RW(RW), .CW(CW)) u_nbr (
    .cat_row (cat_row),
    .cat_col (cat_col),
    .dir     (dir_sel),
    .nbr_row (nbr_row),
    .nbr_col (nbr_col),
    .off_grid(off_grid)
  );

`ifdef CAT_ROUND_ROBIN_EN
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)                   start_dir <= DIR_DOWN;
    else if (state == ST_CLR_OLD) start_dir <= dir_t'(start_dir + 2'd1);
  end
`else
  assign start_dir = DIR_DOWN;
`endif

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state       <= ST_INIT;
      init_row    <= '0;
      init_col    <= '0;
      init_fin    <= 1'b0;
      dir         <= DIR_DOWN;
      probe       <= 2'd0;
      nbr_row_q   <= '0;
      nbr_col_q   <= '0;
      cat_row     <= RW'(CAT_R0);
      cat_col     <= CW'(CAT_C0);
      result      <= RES_MOVED;
      done        <= 1'b0;
      place_ready <= 1'b0;
      mem_en      <= 1'b0;
      mem_we      <= 1'b0;
      mem_row     <= '0;
      mem_col     <= '0;
      mem_wdata   <= CELL_EMPTY;
    end else begin
      state       <= state_n;
      init_row    <= init_row_n;
      init_col    <= init_col_n;
      init_fin    <= init_fin_n;
      dir         <= dir_n;
      probe       <= probe_n;
      nbr_row_q   <= nbr_row_n;
      nbr_col_q   <= nbr_col_n;
      cat_row     <= cat_row_n;
      cat_col     <= cat_col_n;
      result      <= result_n;
      done        <= done_n;
      place_ready <= place_ready_n;
      mem_en      <= mem_en_n;
      mem_we      <= mem_we_n;
      mem_row     <= mem_row_n;
      mem_col     <= mem_col_n;
      mem_wdata   <= mem_wdata_n;
    end
  end

  // Outputs are registered, so each branch schedules the access of the state being entered.
  always_comb begin
    state_n       = state;
    init_row_n    = init_row;
    init_col_n    = init_col;
    init_fin_n    = init_fin;
    dir_n         = dir;
    probe_n       = probe;
    nbr_row_n     = nbr_row_q;
    nbr_col_n     = nbr_col_q;
    cat_row_n     = cat_row;
    cat_col_n     = cat_col;
    result_n      = result;
    done_n        = 1'b0;
    place_ready_n = 1'b0;
    mem_en_n      = 1'b0;
    mem_we_n      = 1'b0;
    mem_row_n     = mem_row;
    mem_col_n     = mem_col;
    mem_wdata_n   = mem_wdata;
    case (state)
      ST_INIT: begin
        if (init_fin) begin
          state_n       = ST_IDLE;
          place_ready_n = 1'b1;
        end else begin
          mem_en_n    = 1'b1;
          mem_we_n    = 1'b1;
          mem_row_n   = init_row;
          mem_col_n   = init_col;
          mem_wdata_n = ((init_row == RW'(CAT_R0)) && (init_col == CW'(CAT_C0))) ? CELL_CAT : CELL_EMPTY;
          if (init_col == CW'(COLS - 1)) begin
            init_col_n = '0;
            if (init_row == RW'(ROWS - 1)) init_fin_n = 1'b1;
            else                           init_row_n = init_row + RW'(1);
          end else begin
            init_col_n = init_col + CW'(1);
          end
        end
      end
      ST_IDLE: begin
        place_ready_n = 1'b1;
        if (place_valid && place_ready) begin
          place_ready_n = 1'b0;
          if (illegal) begin
            result_n = RES_ILLEGAL;
            done_n   = 1'b1;
            state_n  = ST_DONE;
          end else begin
            mem_en_n    = 1'b1;
            mem_we_n    = 1'b1;
            mem_row_n   = place_row;
            mem_col_n   = place_col;
            mem_wdata_n = CELL_BLOCK;
            dir_n       = start_dir;
            probe_n     = 2'd0;
            state_n     = ST_WR_BLOCK;
          end
        end
      end
      ST_WR_BLOCK: begin
        state_n = ST_EVAL;
        if (!off_grid) begin
          mem_en_n  = 1'b1;
          mem_row_n = nbr_row;
          mem_col_n = nbr_col;
          nbr_row_n = nbr_row;
          nbr_col_n = nbr_col;
        end
      end
      ST_EVAL: begin
        if (off_grid) begin
          result_n = RES_ESCAPED;
          done_n   = 1'b1;
          state_n  = ST_DONE;
        end else begin
          state_n = ST_CHK;
        end
      end
      ST_CHK: begin
        if (mem_rdata != CELL_BLOCK) begin
          mem_en_n    = 1'b1;
          mem_we_n    = 1'b1;
          mem_row_n   = nbr_row_q;
          mem_col_n   = nbr_col_q;
          mem_wdata_n = CELL_CAT;
          state_n     = ST_WR_CAT;
        end else if (probe != 2'd3) begin
          probe_n = probe + 2'd1;
          dir_n   = dir_sel;
          state_n = ST_EVAL;
          if (!off_grid) begin
            mem_en_n  = 1'b1;
            mem_row_n = nbr_row;
            mem_col_n = nbr_col;
            nbr_row_n = nbr_row;
            nbr_col_n = nbr_col;
          end
        end else begin
          result_n = RES_TRAPPED;
          done_n   = 1'b1;
          state_n  = ST_DONE;
        end
      end
      ST_WR_CAT: begin
        mem_en_n    = 1'b1;
        mem_we_n    = 1'b1;
        mem_row_n   = cat_row;
        mem_col_n   = cat_col;
        mem_wdata_n = CELL_EMPTY;
        state_n     = ST_CLR_OLD;
      end
      ST_CLR_OLD: begin
        cat_row_n = nbr_row_q;
        cat_col_n = nbr_col_q;
        result_n  = RES_MOVED;
        done_n    = 1'b1;
        state_n   = ST_DONE;
      end
      ST_DONE: begin
        if ((result == RES_MOVED) || (result == RES_ILLEGAL)) begin
          state_n       = ST_IDLE;
          place_ready_n = 1'b1;
        end else begin
          state_n = ST_OVER;
        end
      end
      ST_OVER: begin
        if (restart) begin
          cat_row_n  = RW'(CAT_R0);
          cat_col_n  = CW'(CAT_C0);
          init_row_n = '0;
          init_col_n = '0;
          init_fin_n = 1'b0;
          state_n    = ST_INIT;
        end
      end
      default: state_n = ST_INIT;
    endcase
  end

endmodule

// File: tb/tb_cat_move_sequencer.sv
// Scoreboard bench for cat_move_sequencer: expected memory accesses are queued from a game model and popped as the DUT issues them.
module tb_cat_move_sequencer;

  localparam int ROWS = 6;
  localparam int COLS = 7;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       place_valid = 1'b0;
  logic [2:0] place_row = '0;
  logic [2:0] place_col = '0;
  logic       place_ready;
  logic       restart = 1'b0;
  logic       mem_en, mem_we;
  logic [2:0] mem_row, mem_col;
  logic [1:0] mem_wdata;
  logic [1:0] mem_rdata = '0;
  logic [2:0] cat_row, cat_col;
  logic       busy, done;
  logic [1:0] result;

  int n_checks = 0;
  int n_errors = 0;
  int exp_q[$];
  logic [1:0] mem [8][8];
  int ref_b [ROWS][COLS];
  int m_cr = 3;
  int m_cc = 3;

  cat_move_sequencer dut (
    .Clk(Clk), .Reset(Reset),
    .place_valid(place_valid), .place_row(place_row), .place_col(place_col), .place_ready(place_ready),
    .restart(restart),
    .mem_en(mem_en), .mem_we(mem_we), .mem_row(mem_row), .mem_col(mem_col),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .cat_row(cat_row), .cat_col(cat_col), .busy(busy), .done(done), .result(result)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int acc(input int we, input int r, input int c, input int wd);
    return (we << 8) | (r << 5) | (c << 2) | (we != 0 ? wd : 0);
  endfunction

  // Board memory: one-cycle read latency.
  always @(posedge Clk) begin
    if (mem_en && mem_we)  mem[mem_row][mem_col] <= mem_wdata;
    if (mem_en && !mem_we) mem_rdata <= mem[mem_row][mem_col];
  end

  always @(negedge Clk) begin
    if (mem_en) begin
      if (exp_q.size() == 0) chk("mem_unexpected", 1, 0);
      else chk("mem_access", acc(int'(mem_we), int'(mem_row), int'(mem_col), int'(mem_wdata)), exp_q.pop_front());
    end
  end

  task automatic push_init();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) begin
        ref_b[r][c] = (r == 3 && c == 3) ? 2 : 0;
        exp_q.push_back(acc(1, r, c, ref_b[r][c]));
      end
    m_cr = 3;
    m_cc = 3;
  endtask

  task automatic model_turn(input int r, input int c, output int res, output int lat);
    int nr, nc;
    bit off;
    if (r >= ROWS || c >= COLS || (r == m_cr && c == m_cc)) begin
      res = 3; lat = 1; return;
    end
    exp_q.push_back(acc(1, r, c, 1));
    ref_b[r][c] = 1;
    for (int k = 0; k < 4; k++) begin
      nr = m_cr; nc = m_cc;
      case (k)
        0: begin off = (m_cr == ROWS - 1); nr = m_cr + 1; end
        1: begin off = (m_cr == 0);        nr = m_cr - 1; end
        2: begin off = (m_cc == COLS - 1); nc = m_cc + 1; end
        default: begin off = (m_cc == 0);  nc = m_cc - 1; end
      endcase
      if (off) begin res = 2; lat = 3 + 2 * k; return; end
      exp_q.push_back(acc(0, nr, nc, 0));
      if (ref_b[nr][nc] != 1) begin
        exp_q.push_back(acc(1, nr, nc, 2));
        exp_q.push_back(acc(1, m_cr, m_cc, 0));
        ref_b[nr][nc] = 2;
        ref_b[m_cr][m_cc] = 0;
        m_cr = nr; m_cc = nc;
        res = 0; lat = 6 + 2 * k; return;
      end
    end
    res = 1; lat = 10;
  endtask

  task automatic wait_ready(input string tag, input int bound);
    int n = 0;
    while (!place_ready && n < bound) begin @(negedge Clk); n++; end
    chk({tag, "_ready"}, int'(place_ready), 1);
  endtask

  task automatic place(input int r, input int c, input string tag);
    int res, lat, n;
    model_turn(r, c, res, lat);
    wait_ready(tag, 20);
    place_valid = 1'b1; place_row = 3'(r); place_col = 3'(c);
    @(posedge Clk); #1 place_valid = 1'b0;
    n = 0;
    while (n < 20) begin
      @(negedge Clk); n++;
      if (done) break;
    end
    chk({tag, "_latency"}, n, lat);
    chk({tag, "_result"}, int'(result), res);
    chk({tag, "_cat_row"}, int'(cat_row), m_cr);
    chk({tag, "_cat_col"}, int'(cat_col), m_cc);
    chk({tag, "_sb_left"}, exp_q.size(), 0);
    @(negedge Clk);
    chk({tag, "_done_pulse"}, int'(done), 0);
    chk({tag, "_ready_after"}, int'(place_ready), (res == 0 || res == 3) ? 1 : 0);
  endtask

  task automatic do_restart(input string tag);
    repeat (3) begin
      @(negedge Clk);
      chk({tag, "_over_ready"}, int'(place_ready), 0);
    end
    push_init();
    restart = 1'b1;
    @(negedge Clk);
    restart = 1'b0;
    wait_ready(tag, 100);
    chk({tag, "_sb_left"}, exp_q.size(), 0);
    chk({tag, "_cat_row"}, int'(cat_row), 3);
    chk({tag, "_cat_col"}, int'(cat_col), 3);
  endtask

  initial begin
    #12;
    chk("rst_mem_en", int'(mem_en), 0);
    chk("rst_ready", int'(place_ready), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_result", int'(result), 0);
    chk("rst_cat", int'({cat_row, cat_col}), 8'h1b);
    push_init();
    @(negedge Clk); Reset = 1'b0;
    wait_ready("init", 100);
    chk("init_sb_left", exp_q.size(), 0);
    chk("init_cat", int'({cat_row, cat_col}), 8'h1b);

    place(0, 0, "move1");
    place(0, 1, "move2");
    place(0, 2, "escape");
    do_restart("restart1");

    place(3, 3, "illegal_cat");
    place(6, 0, "illegal_row");
    place(0, 7, "illegal_col");

    mem[4][3] = 2'd1; ref_b[4][3] = 1;
    mem[2][3] = 2'd1; ref_b[2][3] = 1;
    mem[3][2] = 2'd1; ref_b[3][2] = 1;
    place(3, 4, "trapped");
    do_restart("restart2");

    // Abort a turn during the second direction's check.
    mem[4][3] = 2'd1;
    exp_q.push_back(acc(1, 0, 0, 1));
    exp_q.push_back(acc(0, 4, 3, 0));
    exp_q.push_back(acc(0, 2, 3, 0));
    wait_ready("midrst", 20);
    place_valid = 1'b1; place_row = 3'd0; place_col = 3'd0;
    @(posedge Clk); #1 place_valid = 1'b0;
    repeat (5) @(negedge Clk);
    chk("midrst_sb_before", exp_q.size(), 0);
    Reset = 1'b1;
    #1;
    chk("midrst_mem_en", int'(mem_en), 0);
    chk("midrst_cat", int'({cat_row, cat_col}), 8'h1b);
    chk("midrst_ready", int'(place_ready), 0);
    push_init();
    @(negedge Clk); Reset = 1'b0;
    wait_ready("midrst_init", 100);
    chk("midrst_sb_left", exp_q.size(), 0);

    place(4, 3, "move_up");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, errors so far %0d", n_errors);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/cat_move_sequencer.md
Name: cat_move_sequencer

Overview:
Sequences all accesses to the cat-trap board memory (ROWS x COLS cells, 2-bit codes) for one game turn: initialise the board, write the player's blocking cell, probe the cat's neighbours, move the cat.
Sits between the button/pointer front end (place requests) and the board memory read by the VGA renderer.
Reports per-turn outcome (moved / trapped / escaped / illegal) to the top-level game FSM.

Parameters:
ROWS, 6, board rows
COLS, 7, board columns
RW, 3, row index width
CW, 3, column index width
CAT_R0, 3, cat start row
CAT_C0, 3, cat start column

Ports:
Clk  in  1  clock
Reset  in  1  reset
place_valid  in  1  place request
place_row  in  RW  requested block row
place_col  in  CW  requested block column
place_ready  out  1  request accepted when valid&&ready
restart  in  1  one-cycle pulse, leave OVER and re-initialise
mem_en  out  1  memory access strobe
mem_we  out  1  1=write, 0=read
mem_row  out  RW  memory row address
mem_col  out  CW  memory column address
mem_wdata  out  2  write data
mem_rdata  in  2  read data, valid exactly 1 cycle after read strobe
cat_row  out  RW  current cat row
cat_col  out  CW  current cat column
busy  out  1  high in every state except IDLE and OVER
done  out  1  one-cycle pulse, turn finished
result  out  2  00 MOVED, 01 TRAPPED, 10 ESCAPED, 11 ILLEGAL; held until next accept

Behaviour:
- Reset is Reset, asynchronous, active-high; clock is Clk. All state changes on posedge Clk.
- Reset values: state=INIT, init counter=0, cat_row=CAT_R0, cat_col=CAT_C0, result=00, done=0, mem_en=0, place_ready=0.
- Cell codes: 0 EMPTY, 1 BLOCK, 2 CAT.
- INIT: writes one cell per cycle, row-major from (0,0) to (ROWS-1,COLS-1).
  - Data is 2 at (CAT_R0,CAT_C0), 0 elsewhere.
  - Lasts ROWS*COLS cycles (42 by default), then IDLE.
- IDLE: place_ready=1. On accept, the request is ILLEGAL if place_row>=ROWS, place_col>=COLS, or the target equals the cat cell.
  - ILLEGAL: next state DONE with result=11. No memory access.
  - Otherwise: capture the target and go to WR_BLOCK.
- WR_BLOCK: one write of 1 at the target. Re-blocking a BLOCK cell is legal. Direction index d=0.
- EVAL, for direction d in order down(row+1), up(row-1), right(col+1), left(col-1):
  - If the neighbour is off-grid (row 0 going up, row ROWS-1 going down, similarly for columns): result=10, go to DONE. Zero cycles of memory access; EVAL is combined with RD in the same cycle.
  - Otherwise RD issues a read of the neighbour.
- CHK: samples mem_rdata.
  - If not equal to 1: go to WR_CAT.
  - Else if d<3: increment d and return to EVAL/RD.
  - Else: result=01, go to DONE.
- WR_CAT: write 2 at the neighbour.
- CLR_OLD: write 0 at the old cat cell. Update cat_row/cat_col in this cycle. result=00.
- DONE: done=1 for one cycle.
  - result 00 or 11: go to IDLE.
  - result 01 or 10: go to OVER.
- OVER: place_ready=0, no memory access. On restart: cat reset to (CAT_R0,CAT_C0), go to INIT. restart is ignored in every other state.
- Latency from accept (cycle 0):
  - MOVED, first direction free: done in cycle 6.
  - Each blocked direction adds 2 cycles.
  - TRAPPED with all four on-grid: done in cycle 10.
  - ILLEGAL: done in cycle 1.
- Exactly one memory access per cycle at most. mem_en=0 in IDLE, DONE and OVER.
- Reset asserted mid-turn: immediate return to INIT with reset values. Partially written memory is overwritten by the sweep.

Optional Feature:
CAT_ROUND_ROBIN_EN:
- Defined: a 2-bit start-direction register (reset 0) increments after every MOVED turn. Probing starts at that direction and wraps mod 4; still at most 4 probes.
- Undefined: fixed order down, up, right, left.

Decomposition:
- Package cat_trap_pkg holds:
  - cell codes EMPTY/BLOCK/CAT;
  - result codes MOVED/TRAPPED/ESCAPED/ILLEGAL;
  - direction enum DOWN/UP/RIGHT/LEFT;
  - state enum.
- Sub-module cat_nbr_calc: combinational; takes cat position and direction, returns neighbour row/col and off_grid flag. Instantiated once.

Test Plan:
- Reset released -> 42 consecutive write cycles, only (3,3) written with 2; then place_ready=1, cat=(3,3).
- Place (0,0) -> write 1 @ (0,0), read (4,3)=0, write 2 @ (4,3), write 0 @ (3,3); done in cycle 6, result=00, cat=(4,3).
- Place (0,0), then (0,1), then (0,2) -> cat moves to (4,3), then (5,3); third turn result=10 with no reads, OVER, place_ready=0; restart -> INIT sweep, cat=(3,3).
- Bench preloads 1 at (4,3), (2,3), (3,2), then places (3,4) -> four reads, done in cycle 10, result=01, cat unchanged, OVER.
- Place (3,3) or (6,0) -> no mem_en, done in cycle 1, result=11, back to IDLE.
- Reset asserted during CHK of the second direction -> mem_en=0 immediately, cat=(3,3), full 42-cycle INIT sweep repeats.
